// File: rtl/memtest.sv
// memtest: Wishbone memory tester. Writes P(k) = seed + k to a word region,
// reads it back in order, and reports pass / first failing address / mismatch count.
module memtest #(
  parameter int AW = 15,
  parameter int DW = 32
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_start,
  input  logic [AW-1:0] i_base,
  input  logic [AW:0]   i_len,
  input  logic [DW-1:0] i_seed,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_pass,
  output logic [AW-1:0] o_fail_addr,
  output logic [AW:0]   o_fail_count,
  output logic          o_wb_cyc,
  output logic          o_wb_stb,
  output logic          o_wb_we,
  output logic [AW-1:0] o_wb_addr,
  output logic [DW-1:0] o_wb_data,
  input  logic          i_wb_ack,
  input  logic          i_wb_stall,
  input  logic [DW-1:0] i_wb_data
);

  typedef enum logic [2:0] {
    S_IDLE, S_WRITE, S_WDRAIN, S_GAP, S_READ, S_RDRAIN, S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] base_q, base_d;
  logic [AW:0]   len_q, len_d;
  logic [DW-1:0] seed_q, seed_d;
  logic [AW:0]   req_q, req_d;     // requests accepted in current phase
  logic [AW:0]   ack_q, ack_d;     // acks counted in current phase
  logic [AW:0]   fcnt_q, fcnt_d;
  logic [AW-1:0] faddr_q, faddr_d;
  logic          pass_q, pass_d;

  logic accept, ack_ok, rd_phase, mismatch;

  // Bus strobes, acceptance/ack qualification and read-back comparison
  always_comb begin
    o_wb_cyc  = (state_q == S_WRITE) || (state_q == S_WDRAIN) ||
                (state_q == S_READ)  || (state_q == S_RDRAIN);
    o_wb_stb  = (state_q == S_WRITE) || (state_q == S_READ);
    o_wb_we   = (state_q == S_WRITE) || (state_q == S_WDRAIN);
    o_wb_addr = base_q + req_q[AW-1:0];
    o_wb_data = seed_q + DW'(req_q);
    accept    = o_wb_stb && !i_wb_stall;
    // An ack counts only against an outstanding request; one accepted in
    // the same cycle qualifies.
    ack_ok    = o_wb_cyc && i_wb_ack && ((req_q != ack_q) || accept);
    rd_phase  = (state_q == S_READ) || (state_q == S_RDRAIN);
    mismatch  = ack_ok && rd_phase && (i_wb_data != (seed_q + DW'(ack_q)));
  end

  // Next-state, counter and result logic
  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    len_d   = len_q;
    seed_d  = seed_q;
    req_d   = req_q + {{AW{1'b0}}, accept};
    ack_d   = ack_q + {{AW{1'b0}}, ack_ok};
    fcnt_d  = fcnt_q;
    faddr_d = faddr_q;
    pass_d  = pass_q;

    if (mismatch) begin
      if (fcnt_q == '0) faddr_d = base_q + ack_q[AW-1:0];
      if (fcnt_q != '1) fcnt_d = fcnt_q + 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          base_d  = i_base;
          len_d   = i_len;
          seed_d  = i_seed;
          req_d   = '0;
          ack_d   = '0;
          fcnt_d  = '0;
          faddr_d = '0;
          state_d = (i_len != '0) ? S_WRITE : S_DONE;
        end
      end
      S_WRITE:  if (accept && (req_d == len_q)) state_d = S_WDRAIN;
      S_WDRAIN: if (ack_d == len_q) state_d = S_GAP;
      S_GAP: begin
        req_d   = '0;
        ack_d   = '0;
        state_d = S_READ;
      end
      S_READ:   if (accept && (req_d == len_q)) state_d = S_RDRAIN;
      S_RDRAIN: if (ack_d == len_q) state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    // Verdict registered on entry to DONE so it is valid during the pulse,
    // including a mismatch on the final read ack.
    if ((state_d == S_DONE) && (state_q != S_DONE)) pass_d = (fcnt_d == '0);
  end

  // State and datapath registers
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      base_q  <= '0;
      len_q   <= '0;
      seed_q  <= '0;
      req_q   <= '0;
      ack_q   <= '0;
      fcnt_q  <= '0;
      faddr_q <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      len_q   <= len_d;
      seed_q  <= seed_d;
      req_q   <= req_d;
      ack_q   <= ack_d;
      fcnt_q  <= fcnt_d;
      faddr_q <= faddr_d;
      pass_q  <= pass_d;
    end
  end

  assign o_busy       = (state_q != S_IDLE);
  assign o_done       = (state_q == S_DONE);
  assign o_pass       = pass_q;
  assign o_fail_addr  = faddr_q;
  assign o_fail_count = fcnt_q;

endmodule

// File: tb/tb_memtest.sv
// tb_memtest: randomized scoreboard bench for memtest with a Wishbone memory model.
module tb_memtest;
  localparam int AW = 6;
  localparam int DW = 32;
  localparam int NW = 1 << AW;

  logic          clk = 1'b0, rst = 1'b0, start = 1'b0;
  logic [AW-1:0] base = '0;
  logic [AW:0]   len = '0;
  logic [DW-1:0] seed = '0;
  logic          busy, done, pass;
  logic [AW-1:0] fail_addr;
  logic [AW:0]   fail_count;
  logic          wb_cyc, wb_stb, wb_we;
  logic [AW-1:0] wb_addr;
  logic [DW-1:0] wb_wdata;
  logic          ack = 1'b0, stall = 1'b0;
  logic [DW-1:0] rdata = '0;

  memtest #(.AW(AW), .DW(DW)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_base(base), .i_len(len), .i_seed(seed),
    .o_busy(busy), .o_done(done), .o_pass(pass), .o_fail_addr(fail_addr),
    .o_fail_count(fail_count), .o_wb_cyc(wb_cyc), .o_wb_stb(wb_stb), .o_wb_we(wb_we),
    .o_wb_addr(wb_addr), .o_wb_data(wb_wdata), .i_wb_ack(ack), .i_wb_stall(stall),
    .i_wb_data(rdata)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name);
    checks++;
    fails++;
    $display("FAIL %s: event with empty scoreboard", name);
  endtask

  // Scoreboard queues filled by the reference model
  typedef struct { logic [AW-1:0] addr; logic [DW-1:0] data; } wr_t;
  typedef struct { logic p; logic [AW-1:0] fa; logic [AW:0] fc; } res_t;
  wr_t           exp_wr[$];
  logic [AW-1:0] exp_rd[$];
  res_t          exp_res[$];

  // Slave model configuration
  bit            stall_en = 0;
  int            max_lat = 1;
  bit            corrupt_en = 0;
  logic [AW-1:0] corrupt_addr = '0;

  typedef struct { int ready; logic [DW-1:0] data; } resp_t;
  resp_t         pq[$];
  logic [DW-1:0] mem [NW];
  int            cyc_n = 0;

  // Memory slave: captures requests at negedge, presents in-order acks after posedge
  initial begin
    resp_t r;
    forever begin
      @(negedge clk);
      if (rst) pq.delete();
      else begin
        if (wb_cyc && ack && pq.size() > 0) void'(pq.pop_front());
        if (wb_cyc && wb_stb && !stall) begin
          r.ready = cyc_n + int'($urandom_range(max_lat, 1));
          if (wb_we) begin
            mem[wb_addr] = wb_wdata;
            r.data = '0;
          end else
            r.data = (corrupt_en && wb_addr == corrupt_addr) ? '0 : mem[wb_addr];
          pq.push_back(r);
        end
      end
      @(posedge clk);
      #1;
      cyc_n++;
      if (!rst && pq.size() > 0 && pq[0].ready <= cyc_n) begin
        ack = 1'b1;
        rdata = pq[0].data;
      end else begin
        ack = 1'b0;
        rdata = $urandom;
      end
      stall = stall_en ? 1'($urandom_range(1, 0)) : 1'b0;
    end
  end

  // Monitor: pops scoreboard on accepted requests and on o_done; bus rule checks
  int            mon_out = 0;
  int            stb_cycles = 0;
  bit            cyc_seen = 0;
  bit            prev_hold = 0;
  logic [AW-1:0] prev_addr;
  logic [DW-1:0] prev_data;
  initial begin
    wr_t  w;
    res_t e;
    logic [AW-1:0] a;
    forever begin
      @(negedge clk);
      if (rst) begin
        mon_out = 0;
        prev_hold = 0;
      end else begin
        if (prev_hold && wb_stb) begin
          chk("stall_addr_hold", 64'(wb_addr), 64'(prev_addr));
          chk("stall_data_hold", 64'(wb_wdata), 64'(prev_data));
        end
        if (!wb_cyc && busy) chk("cyc_low_outstanding", 64'(mon_out), 64'd0);
        if (wb_cyc && wb_stb && !stall) begin
          mon_out++;
          if (wb_we) begin
            if (exp_wr.size() == 0) unexpected("write_req");
            else begin
              w = exp_wr.pop_front();
              chk("write_addr", 64'(wb_addr), 64'(w.addr));
              chk("write_data", 64'(wb_wdata), 64'(w.data));
            end
          end else begin
            if (exp_rd.size() == 0) unexpected("read_req");
            else begin
              a = exp_rd.pop_front();
              chk("read_addr", 64'(wb_addr), 64'(a));
            end
          end
        end
        if (wb_cyc && ack && mon_out > 0) mon_out--;
        if (wb_stb) stb_cycles++;
        if (wb_cyc) cyc_seen = 1;
        prev_hold = wb_stb && stall;
        prev_addr = wb_addr;
        prev_data = wb_wdata;
        if (done) begin
          if (exp_res.size() == 0) unexpected("done_pulse");
          else begin
            e = exp_res.pop_front();
            chk("pass", 64'(pass), 64'(e.p));
            chk("fail_addr", 64'(fail_addr), 64'(e.fa));
            chk("fail_count", 64'(fail_count), 64'(e.fc));
          end
        end
      end
    end
  end

  // One complete test: reference model fills the scoreboard, then start is pulsed
  task automatic run_test(input logic [AW-1:0] b, input int l, input logic [DW-1:0] s,
                          input bit st_en, input int lat, input bit c_en,
                          input logic [AW-1:0] c_addr, input bit poke);
    res_t r;
    int   iter;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    r.p = 1'b1; r.fa = '0; r.fc = '0;
    for (int k = 0; k < l; k++) begin
      a = AW'((int'(b) + k) % NW);
      d = s + DW'(k);
      exp_wr.push_back('{addr: a, data: d});
      exp_rd.push_back(a);
      if (c_en && a == c_addr && d != '0) begin
        if (r.fc == '0) r.fa = a;
        if (r.fc != '1) r.fc = r.fc + 1'b1;
      end
    end
    r.p = (r.fc == '0);
    exp_res.push_back(r);

    stall_en = st_en; max_lat = lat; corrupt_en = c_en; corrupt_addr = c_addr;
    @(negedge clk);
    stb_cycles = 0;
    cyc_seen = 0;
    start = 1'b1; base = b; len = (AW+1)'(l); seed = s;
    @(negedge clk);
    start = 1'b0; base = AW'($urandom); len = (AW+1)'($urandom); seed = $urandom;
    #1;
    iter = 0;
    while (!done && iter < 3000) begin
      @(negedge clk);
      if (poke && iter == 3) start = 1'b1;
      if (poke && iter == 4) start = 1'b0;
      #1;
      iter++;
    end
    start = 1'b0;
    if (iter >= 3000) begin
      chk("done_timeout", 64'(iter), 64'd0);
      exp_wr.delete(); exp_rd.delete(); exp_res.delete();
    end
    @(posedge clk);
    #1;
    chk("writes_outstanding", 64'(exp_wr.size()), 64'd0);
    chk("reads_outstanding", 64'(exp_rd.size()), 64'd0);
    chk("results_outstanding", 64'(exp_res.size()), 64'd0);
    if (!st_en && lat == 1) chk("stb_cycle_count", 64'(stb_cycles), 64'(2 * l));
    if (l == 0) begin
      chk("len0_done_latency", 64'(iter), 64'd0);
      chk("len0_no_cyc", 64'(cyc_seen), 64'd0);
    end
    if (poke) begin
      repeat (3) @(negedge clk);
      chk("no_queued_restart", 64'(busy), 64'd0);
    end
  endtask

  initial begin
    int iter;
    #1 rst = 1'b1;
    #2;
    chk("rst_cyc", 64'(wb_cyc), 64'd0);
    chk("rst_stb", 64'(wb_stb), 64'd0);
    chk("rst_we", 64'(wb_we), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_pass", 64'(pass), 64'd0);
    chk("rst_fail_addr", 64'(fail_addr), 64'd0);
    chk("rst_fail_count", 64'(fail_count), 64'd0);
    chk("rst_addr", 64'(wb_addr), 64'd0);
    chk("rst_data", 64'(wb_wdata), 64'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Directed cases
    run_test(6'h10, 4, 32'h100, 0, 1, 0, '0, 0);
    run_test(6'h10, 4, 32'h100, 0, 1, 1, 6'h12, 0);
    run_test(6'h10, 16, 32'h100, 1, 3, 0, '0, 0);
    run_test(6'h05, 0, 32'h1234, 0, 1, 0, '0, 0);
    run_test(6'h3E, 4, 32'hFFFF_FFFF, 0, 1, 0, '0, 0);
    run_test(6'h00, NW, 32'hA5A5_0000, 0, 1, 0, '0, 0);
    run_test(6'h20, 6, 32'h55, 0, 1, 1, 6'h23, 1);

    // Randomized cases
    for (int t = 0; t < 8; t++) begin
      run_test(AW'($urandom), int'($urandom_range(20, 1)), $urandom, 1, 3,
               1'($urandom_range(1, 0)), AW'($urandom), 0);
    end

    // Reset in the middle of the read phase
    stall_en = 1; max_lat = 3; corrupt_en = 0;
    exp_wr.push_back('{addr: '0, data: '0});
    @(negedge clk);
    start = 1'b1; base = 6'h08; len = 7'd16; seed = 32'h77;
    @(negedge clk);
    start = 1'b0;
    exp_wr.delete(); exp_rd.delete(); exp_res.delete();
    for (int k = 0; k < 16; k++) exp_wr.push_back('{addr: AW'(8 + k), data: 32'h77 + DW'(k)});
    for (int k = 0; k < 16; k++) exp_rd.push_back(AW'(8 + k));
    iter = 0;
    while (!(wb_cyc && !wb_we) && iter < 2000) begin
      @(negedge clk);
      iter++;
    end
    chk("reach_read_phase", 64'(iter < 2000), 64'd1);
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    ack = 1'b0;
    #1;
    chk("midrst_cyc", 64'(wb_cyc), 64'd0);
    chk("midrst_stb", 64'(wb_stb), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    exp_wr.delete(); exp_rd.delete(); exp_res.delete();
    repeat (2) begin
      @(negedge clk);
      chk("midrst_no_done", 64'(done), 64'd0);
    end
    @(negedge clk);
    rst = 1'b0;
    run_test(6'h30, 2, 32'hDEAD_BEEF, 1, 2, 0, '0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
